// File: rtl/serialdump.sv
// ---------------------------------------------------------------------------
// serialdump
//
// Memory-to-UART hex dumper. When started, it takes over the memory port and
// reads a programmed number of 32-bit words from a start address. Each word
// goes to the UART transmitter as eight lowercase ASCII hex characters, most
// significant nibble first. A single space (0x20) follows the last word. The
// resulting stream can be fed straight back into the serial boot loader.
//
// Optional feature macro: SERIALDUMP_NEWLINE_EN
//   When defined, a 0x0A character is sent after every word (state NL).
//
// Ports
//   clk, rst                  system clock, asynchronous active-low reset
//   a, d, we, ready           control port (write-only registers):
//                             a=1 start address (byte-swapped from d),
//                             a=2 word count, a=3 start dump.
//                             ready is low while a dump runs.
//   *_cpu                     CPU-side memory request / response
//   *_mem                     memory-side request / response
//   tx_data, tx_start,        UART TX character, one-cycle send pulse,
//   tx_busy                   and busy flag
// ---------------------------------------------------------------------------
module serialdump (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic        ready,
  input  logic        burst_en_cpu,
  input  logic [7:0]  burst_length_cpu,
  input  logic [31:0] a_cpu,
  input  logic [31:0] d_cpu,
  input  logic        we_cpu,
  input  logic        rd_cpu,
  output logic [31:0] spo_cpu,
  output logic        ready_cpu,
  output logic        burst_en_mem,
  output logic [7:0]  burst_length_mem,
  output logic [31:0] a_mem,
  output logic [31:0] d_mem,
  output logic        we_mem,
  output logic        rd_mem,
  input  logic [31:0] spo_mem,
  input  logic        ready_mem,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_GAP,
    ST_NEXT,
    ST_TERM,
    ST_TGAP
`ifdef SERIALDUMP_NEWLINE_EN
    , ST_NL
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  // Set once the mandatory first GAP/TGAP cycle has elapsed, so tx_busy is
  // only sampled after the UART has had a cycle to raise it.
  logic        armed_q, armed_d;
`ifdef SERIALDUMP_NEWLINE_EN
  // Marks that the character in flight is the newline, so GAP exits to NEXT.
  logic        nl_q, nl_d;
`endif

  logic        rd_int;
  logic        override;
  logic [2:0]  nib_sel;
  logic [3:0]  nib;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    else           return 8'h57 + {4'h0, v};
  endfunction

  // Index 0 selects the most significant nibble.
  assign nib_sel = 3'd7 - idx_q;
  assign nib     = data_q[{nib_sel, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      count_q <= 16'h0;
      data_q  <= 32'h0;
      idx_q   <= 3'd0;
      armed_q <= 1'b0;
`ifdef SERIALDUMP_NEWLINE_EN
      nl_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
`ifdef SERIALDUMP_NEWLINE_EN
      nl_q    <= nl_d;
`endif
    end
  end

  // Next-state and datapath. tx_start is combinational so it can only be
  // high in a cycle where tx_busy is low.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    data_d   = data_q;
    idx_d    = idx_q;
    armed_d  = armed_q;
`ifdef SERIALDUMP_NEWLINE_EN
    nl_d     = nl_q;
`endif
    rd_int   = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (we) begin
          case (a)
            3'd1: addr_d = {d[7:0], d[15:8], d[23:16], d[31:24]};
            3'd2: count_d = d[15:0];
            3'd3: state_d = (count_q != 16'd0) ? ST_READ : ST_TERM;
            default: ;
          endcase
        end
      end
      ST_READ: begin
        rd_int = 1'b1;
        if (ready_mem) begin
          data_d  = spo_mem;
          idx_d   = 3'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = hex_char(nib);
          armed_d  = 1'b0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (!tx_busy) begin
`ifdef SERIALDUMP_NEWLINE_EN
          if (nl_q) begin
            nl_d    = 1'b0;
            state_d = ST_NEXT;
          end else if (idx_q != 3'd7) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_NL;
          end
`else
          if (idx_q != 3'd7) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_NEXT;
          end
`endif
        end
      end
`ifdef SERIALDUMP_NEWLINE_EN
      ST_NL: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = 8'h0A;
          armed_d  = 1'b0;
          nl_d     = 1'b1;
          state_d  = ST_GAP;
        end
      end
`endif
      ST_NEXT: begin
        addr_d  = addr_q + 32'd4;
        count_d = count_q - 16'd1;
        state_d = (count_q != 16'd1) ? ST_READ : ST_TERM;
      end
      ST_TERM: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = 8'h20;
          armed_d  = 1'b0;
          state_d  = ST_TGAP;
        end
      end
      ST_TGAP: begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The memory port belongs to the dumper in every non-idle state; since this
  // decodes the state register directly, an async reset drops it at once.
  assign override = (state_q != ST_IDLE);
  assign ready    = (state_q == ST_IDLE);

  assign a_mem            = override ? addr_q : a_cpu;
  assign rd_mem           = override ? rd_int : rd_cpu;
  assign we_mem           = override ? 1'b0   : we_cpu;
  assign burst_en_mem     = override ? 1'b0   : burst_en_cpu;
  assign burst_length_mem = override ? 8'h00  : burst_length_cpu;
  assign d_mem            = override ? 32'h0  : d_cpu;

  assign spo_cpu   = spo_mem;
  assign ready_cpu = ready_mem;

endmodule

// File: tb/tb_serialdump.sv
// ---------------------------------------------------------------------------
// tb_serialdump
//
// Directed bench for serialdump. Includes a small memory model with an
// adjustable read latency and a UART model with an adjustable busy time.
// A monitor records every transmitted character, every completed read
// address, and the length of each rd_mem high run.
// ---------------------------------------------------------------------------
module tb_serialdump;

  logic        clk;
  logic        rst;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic        ready;
  logic        burst_en_cpu;
  logic [7:0]  burst_length_cpu;
  logic [31:0] a_cpu;
  logic [31:0] d_cpu;
  logic        we_cpu;
  logic        rd_cpu;
  logic [31:0] spo_cpu;
  logic        ready_cpu;
  logic        burst_en_mem;
  logic [7:0]  burst_length_mem;
  logic [31:0] a_mem;
  logic [31:0] d_mem;
  logic        we_mem;
  logic        rd_mem;
  logic [31:0] spo_mem;
  logic        ready_mem;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;

  int checks = 0;
  int failures = 0;

  serialdump dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .ready(ready),
    .burst_en_cpu(burst_en_cpu), .burst_length_cpu(burst_length_cpu),
    .a_cpu(a_cpu), .d_cpu(d_cpu), .we_cpu(we_cpu), .rd_cpu(rd_cpu),
    .spo_cpu(spo_cpu), .ready_cpu(ready_cpu),
    .burst_en_mem(burst_en_mem), .burst_length_mem(burst_length_mem),
    .a_mem(a_mem), .d_mem(d_mem), .we_mem(we_mem), .rd_mem(rd_mem),
    .spo_mem(spo_mem), .ready_mem(ready_mem),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fixed contents, ready after mem_delay waiting cycles.
  int mem_delay = 0;
  int wait_cnt = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    case (addr)
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0104: return 32'h0123_ABCD;
      32'h0000_0108: return 32'h7654_3210;
      32'hFFFF_FFFC: return 32'hCAFE_F00D;
      32'h0000_0000: return 32'h89AB_CDEF;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  assign spo_mem   = mem_rd(a_mem);
  assign ready_mem = rd_mem && (wait_cnt == mem_delay);

  always @(posedge clk) begin
    if (rd_mem && !ready_mem) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // UART model: busy for busy_len cycles starting the cycle after tx_start.
  int busy_len = 0;
  int uart_cnt = 0;

  assign tx_busy = (uart_cnt != 0);

  always @(posedge clk) begin
    if (tx_start && busy_len != 0) uart_cnt <= busy_len;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end

  // Monitor, sampling well after the negedge where stimulus changes.
  logic [7:0]  chars[$];
  logic [31:0] read_addrs[$];
  int          runs[$];
  int          run = 0;
  int          rd_total = 0;
  int          busy_viol = 0;
  int          ready_viol = 0;
  int          samp = 0;
  int          last_start = 0;
  bit          have_last = 1'b0;
  int          min_gap = 1000000;

  always begin
    @(negedge clk);
    #2;
    samp++;
    if (tx_start) begin
      chars.push_back(tx_data);
      if (tx_busy) busy_viol++;
      if (ready) ready_viol++;
      if (have_last && (samp - last_start) < min_gap) min_gap = samp - last_start;
      last_start = samp;
      have_last = 1'b1;
    end
    if (rd_mem && ready_mem) read_addrs.push_back(a_mem);
    if (rd_mem) begin
      rd_total++;
      run++;
    end else if (run != 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] sel, input logic [31:0] data);
    @(negedge clk);
    a = sel;
    d = data;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    a = 3'd0;
    d = 32'h0;
  endtask

  task automatic clear_monitor();
    chars.delete();
    read_addrs.delete();
    runs.delete();
    rd_total = 0;
    busy_viol = 0;
    ready_viol = 0;
    have_last = 1'b0;
    min_gap = 1000000;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input string exp);
    check_output({tag, "_len"}, 32'(chars.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      check_output($sformatf("%s[%0d]", tag, i),
                   (i < chars.size()) ? {24'h0, chars[i]} : 32'hFFFF_FFFF,
                   {24'h0, exp[i]});
    end
  endtask

  task automatic start_dump(input logic [31:0] swapped_addr, input logic [31:0] count);
    apply_stimulus(3'd1, swapped_addr);
    apply_stimulus(3'd2, count);
    apply_stimulus(3'd3, 32'h0);
  endtask

  // Expected streams, written out by hand.
`ifdef SERIALDUMP_NEWLINE_EN
  string exp_two   = "deadbeef\n0123abcd\n ";
  string exp_one   = "deadbeef\n ";
  string exp_108   = "76543210\n ";
  string exp_wrap  = "cafef00d\n89abcdef\n ";
  string exp_104   = "0123abcd\n ";
`else
  string exp_two   = "deadbeef0123abcd ";
  string exp_one   = "deadbeef ";
  string exp_108   = "76543210 ";
  string exp_wrap  = "cafef00d89abcdef ";
  string exp_104   = "0123abcd ";
`endif

  initial begin
    rst = 1'b0;
    a = 3'd0;
    d = 32'h0;
    we = 1'b0;
    burst_en_cpu = 1'b1;
    burst_length_cpu = 8'h10;
    a_cpu = 32'h1234_5678;
    d_cpu = 32'h1111_2222;
    we_cpu = 1'b0;
    rd_cpu = 1'b1;

    // Reset state and pass-through.
    repeat (3) @(negedge clk);
    #1;
    check_output("rst_ready", 32'(ready), 32'd1);
    check_output("rst_tx_start", 32'(tx_start), 32'd0);
    check_output("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check_output("rst_rd_mem", 32'(rd_mem), 32'd1);
    check_output("rst_a_mem", a_mem, 32'h1234_5678);
    check_output("rst_burst_len", {24'h0, burst_length_mem}, 32'h10);
    check_output("rst_spo_cpu", spo_cpu, 32'h0);
    check_output("rst_ready_cpu", 32'(ready_cpu), 32'd1);
    @(negedge clk);
    rd_cpu = 1'b0;
    burst_en_cpu = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_monitor();

    // Two words from 0x100 with single-cycle memory and idle TX.
    start_dump(32'h0001_0000, 32'd2);
    #1;
    check_output("t1_ready_low", 32'(ready), 32'd0);
    wait_idle(2000, "t1_timeout");
    check_stream("t1", exp_two);
    check_output("t1_ready_viol", 32'(ready_viol), 32'd0);
    check_output("t1_runs", 32'(runs.size()), 32'd2);
    if (runs.size() == 2) check_output("t1_run_len", 32'(runs[0]), 32'd1);
    check_output("t1_addr1", (read_addrs.size() > 1) ? read_addrs[1] : 32'hX, 32'h0000_0104);

    // Count ended at 0, so a bare start sends only the space.
    clear_monitor();
    apply_stimulus(3'd3, 32'h0);
    wait_idle(200, "t2_timeout");
    check_stream("t2", " ");
    check_output("t2_rd_total", 32'(rd_total), 32'd0);

    // Memory answering after 5 waiting cycles.
    clear_monitor();
    mem_delay = 5;
    start_dump(32'h0001_0000, 32'd2);
    wait_idle(2000, "t3_timeout");
    check_stream("t3", exp_two);
    check_output("t3_runs", 32'(runs.size()), 32'd2);
    if (runs.size() == 2) begin
      check_output("t3_run0", 32'(runs[0]), 32'd6);
      check_output("t3_run1", 32'(runs[1]), 32'd6);
    end
    mem_delay = 0;

    // Address register kept its final value 0x108; reprogram only the count.
    clear_monitor();
    apply_stimulus(3'd2, 32'd1);
    apply_stimulus(3'd3, 32'h0);
    wait_idle(1000, "t4_timeout");
    check_output("t4_addr", (read_addrs.size() > 0) ? read_addrs[0] : 32'hX, 32'h0000_0108);
    check_stream("t4", exp_108);

    // Slow UART: 100 busy cycles per character.
    clear_monitor();
    busy_len = 100;
    start_dump(32'h0001_0000, 32'd1);
    wait_idle(5000, "t5_timeout");
    check_stream("t5", exp_one);
    check_output("t5_busy_viol", 32'(busy_viol), 32'd0);
    check_output("t5_min_gap_ge_101", 32'(min_gap >= 101), 32'd1);
    busy_len = 0;

    // Address wrap-around.
    clear_monitor();
    start_dump(32'hFCFF_FFFF, 32'd2);
    wait_idle(2000, "t6_timeout");
    check_output("t6_addr0", (read_addrs.size() > 0) ? read_addrs[0] : 32'hX, 32'hFFFF_FFFC);
    check_output("t6_addr1", (read_addrs.size() > 1) ? read_addrs[1] : 32'hX, 32'h0000_0000);
    check_stream("t6", exp_wrap);

    // Reset after the third character.
    clear_monitor();
    a_cpu = 32'hA5A5_0000;
    rd_cpu = 1'b1;
    we_cpu = 1'b1;
    start_dump(32'h0001_0000, 32'd2);
    begin
      int n = 0;
      while (chars.size() < 3 && n < 500) begin
        @(negedge clk);
        n++;
      end
      check_output("t7_third_char_timeout", 32'(n < 500), 32'd1);
    end
    #1;
    check_output("t7_ovr_a_mem", a_mem, 32'h0000_0100);
    check_output("t7_ovr_rd_mem", 32'(rd_mem), 32'd0);
    check_output("t7_ovr_we_mem", 32'(we_mem), 32'd0);
    check_output("t7_ovr_d_mem", d_mem, 32'h0);
    rst = 1'b0;
    #1;
    check_output("t7_rst_ready", 32'(ready), 32'd1);
    check_output("t7_rst_tx_start", 32'(tx_start), 32'd0);
    check_output("t7_rst_a_mem", a_mem, 32'hA5A5_0000);
    check_output("t7_rst_rd_mem", 32'(rd_mem), 32'd1);
    check_output("t7_rst_we_mem", 32'(we_mem), 32'd1);
    repeat (4) @(negedge clk);
    check_output("t7_chars_frozen", 32'(chars.size()), 32'd3);
    rst = 1'b1;
    rd_cpu = 1'b0;
    we_cpu = 1'b0;
    @(negedge clk);
    clear_monitor();
    start_dump(32'h0401_0000, 32'd1);
    wait_idle(1000, "t7_timeout");
    check_output("t7_addr", (read_addrs.size() > 0) ? read_addrs[0] : 32'hX, 32'h0000_0104);
    check_stream("t7", exp_104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
